// File: rtl/register_file.sv
// 31-entry, two-read/one-write integer register file with x0 hardwired to zero,
// write-first bypass on both read ports, and a count of committed writes.
module register_file #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] writeback,
  input  logic         wb_enable,
  input  logic [4:0]   rd_addr,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  output logic [n-1:0] rs1_data,
  output logic [n-1:0] rs2_data,
  output logic [31:0]  wb_count
);

  logic [n-1:0] regs_q [1:31];
  logic [n-1:0] regs_d [1:31];
  logic [31:0]  wb_count_q;
  logic [31:0]  wb_count_d;
  logic         commit;

  assign commit = wb_enable && (rd_addr != 5'd0);

  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    for (int unsigned i = 1; i < 32; i++) begin
      if (commit && (rd_addr == 5'(i))) begin
        regs_d[i] = writeback;
      end
    end
    if (commit) begin
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Bypass is deliberately independent of rst so reads see pending writeback.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (rs1_addr == 5'(i)) begin
        rs1_data = regs_q[i];
      end
      if (rs2_addr == 5'(i)) begin
        rs2_data = regs_q[i];
      end
    end
    if (commit && (rs1_addr == rd_addr)) begin
      rs1_data = writeback;
    end
    if (commit && (rs2_addr == rd_addr)) begin
      rs2_data = writeback;
    end
  end

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, x0, bypass, sweep and
// mid-run reset, each checked with an immediate assertion.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [31:0] writeback;
  logic        wb_enable;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_count;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  register_file #(.n(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .writeback (writeback),
    .wb_enable (wb_enable),
    .rd_addr   (rd_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst       = 1'b1;
    wb_enable = 1'b0;
    writeback = '0;
    rd_addr   = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;
    #2;

    // Reset: every index reads zero, counter zero
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check("reset_rs1", rs1_data, 32'h0);
      check("reset_rs2", rs2_data, 32'h0);
    end
    check("reset_count", wb_count, 32'd0);

    // Write attempt while in reset: ignored, bypass still visible
    step();
    wb_enable = 1'b1;
    rd_addr   = 5'd7;
    writeback = 32'hDEAD_BEEF;
    rs1_addr  = 5'd7;
    rs2_addr  = 5'd0;
    #1;
    check("rst_bypass_rs1", rs1_data, 32'hDEAD_BEEF);
    check("rst_bypass_rs2_x0", rs2_data, 32'h0);
    step();
    wb_enable = 1'b0;
    #1;
    check("rst_write_ignored", rs1_data, 32'h0);
    check("rst_write_count", wb_count, 32'd0);

    // Release reset mid-cycle with a write presented on the next edge
    wb_enable = 1'b1;
    rd_addr   = 5'd3;
    writeback = 32'h0051_0193;
    rs1_addr  = 5'd3;
    rs2_addr  = 5'd3;
    #1;
    rst = 1'b0;
    step();
    wb_enable = 1'b0;
    writeback = 32'h0;
    #1;
    check("wr_x3_rs1", rs1_data, 32'h0051_0193);
    check("wr_x3_rs2", rs2_data, 32'h0051_0193);
    check("wr_x3_count", wb_count, 32'd1);

    // Write to x0 is discarded and never bypassed
    wb_enable = 1'b1;
    rd_addr   = 5'd0;
    writeback = 32'h9999_9999;
    rs1_addr  = 5'd0;
    rs2_addr  = 5'd0;
    #1;
    check("x0_bypass_rs1", rs1_data, 32'h0);
    check("x0_bypass_rs2", rs2_data, 32'h0);
    step();
    wb_enable = 1'b0;
    #1;
    check("x0_rs1", rs1_data, 32'h0);
    check("x0_rs2", rs2_data, 32'h0);
    check("x0_count", wb_count, 32'd1);

    // Same-cycle bypass on rs1, stored value on rs2
    wb_enable = 1'b1;
    rd_addr   = 5'd5;
    writeback = 32'h2323_2323;
    rs1_addr  = 5'd5;
    rs2_addr  = 5'd3;
    #1;
    check("bypass_rs1", rs1_data, 32'h2323_2323);
    check("bypass_rs2_other", rs2_data, 32'h0051_0193);
    step();
    wb_enable = 1'b0;
    writeback = 32'hFFFF_FFFF;
    #1;
    check("bypass_committed", rs1_data, 32'h2323_2323);
    check("disabled_no_bypass", rs1_data, 32'h2323_2323);
    step();
    check("disabled_kept", rs1_data, 32'h2323_2323);
    check("disabled_count", wb_count, 32'd2);

    // Both ports bypass the same index
    wb_enable = 1'b1;
    writeback = 32'h5A5A_5A5A;
    rs2_addr  = 5'd5;
    #1;
    check("dual_bypass_rs1", rs1_data, 32'h5A5A_5A5A);
    check("dual_bypass_rs2", rs2_data, 32'h5A5A_5A5A);
    step();
    wb_enable = 1'b0;
    #1;
    check("dual_count", wb_count, 32'd3);

    // Mid-run reset between edges clears state immediately
    rst = 1'b1;
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;
    #1;
    check("midrst1_x3", rs1_data, 32'h0);
    check("midrst1_x5", rs2_data, 32'h0);
    check("midrst1_count", wb_count, 32'd0);
    #1;
    rst = 1'b0;

    // Sweep x1..x31
    for (int i = 1; i < 32; i++) begin
      wb_enable = 1'b1;
      rd_addr   = 5'(i);
      writeback = 32'h1010_1010 + 32'(i);
      step();
    end
    wb_enable = 1'b0;
    writeback = '0;
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(32 - i);
      #1;
      check("sweep_rs1", rs1_data, 32'h1010_1010 + 32'(i));
      check("sweep_rs2", rs2_data, 32'h1010_1010 + 32'(32 - i));
    end
    check("sweep_count", wb_count, 32'd31);

    // Mid-run reset after the sweep
    step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #0;
      check("midrst2_rs1", rs1_data, 32'h0);
      check("midrst2_rs2", rs2_data, 32'h0);
    end
    check("midrst2_count", wb_count, 32'd0);

    // First write after release behaves as after power-on
    step();
    wb_enable = 1'b1;
    rd_addr   = 5'd9;
    writeback = 32'hCAFE_F00D;
    #1;
    rst = 1'b0;
    step();
    wb_enable = 1'b0;
    rs1_addr  = 5'd9;
    rs2_addr  = 5'd10;
    #1;
    check("post_rst_x9", rs1_data, 32'hCAFE_F00D);
    check("post_rst_x10", rs2_data, 32'h0);
    check("post_rst_count", wb_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the data width of every register and data port.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port writeback, input, n, write data driven by the writeback mux.
REQ-005 The block SHALL have port wb_enable, input, 1, write strobe for the current cycle.
REQ-006 The block SHALL have port rd_addr, input, 5, destination register index.
REQ-007 The block SHALL have port rs1_addr, input, 5, read port 1 index.
REQ-008 The block SHALL have port rs2_addr, input, 5, read port 2 index.
REQ-009 The block SHALL have port rs1_data, output, n, read port 1 data.
REQ-010 The block SHALL have port rs2_data, output, n, read port 2 data.
REQ-011 The block SHALL have port wb_count, output, 32, count of committed register writes.

Function
REQ-012 The block SHALL hold 31 storage registers, x1..x31, each n bits wide; x0 SHALL have no storage.
REQ-013 A read of index 0 on either port SHALL return 0 in all cases.
REQ-014 Reads SHALL be combinational: rs1_data and rs2_data SHALL follow their addresses within the same cycle.
REQ-015 On a rising clk edge with wb_enable=1 and rd_addr!=0, x[rd_addr] SHALL take the value of writeback.
REQ-016 A write with rd_addr=0 SHALL be discarded, SHALL change no storage, and SHALL NOT increment wb_count.
REQ-017 With wb_enable=0, no storage SHALL change, whatever writeback and rd_addr hold.
REQ-018 Same-cycle bypass: when wb_enable=1, rd_addr!=0 and rsN_addr==rd_addr, rsN_data SHALL equal writeback (write-first), not the stored value.
REQ-019 Both read ports SHALL be able to read the same index at once, and SHALL both apply the bypass when it matches.
REQ-020 wb_count SHALL increment by 1 on each clk edge that commits a write (REQ-015), and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 Storage SHALL change only at a clk edge, never on a change of a combinational input.
REQ-022 rd_addr, rs1_addr and rs2_addr SHALL all be fully decoded; every one of the 32 indices is valid and no input is ignored.

Reset
REQ-023 While rst=1, x1..x31 and wb_count SHALL be 0, without waiting for a clk edge.
REQ-024 While rst=1, a write attempt (wb_enable=1) SHALL be ignored; the bypass SHALL remain active on the read ports.
REQ-025 A write presented on the clk edge at which rst deasserts SHALL be committed normally.
REQ-026 If rst asserts mid-run, all stored state SHALL clear immediately, and the first edge after release SHALL behave as after power-on reset.

Verification
REQ-027 Reset: assert rst, read all 32 indices -> every read returns 0 and wb_count=0.
REQ-028 Write/read: write 0x00510193 to x3, then read x3 on rs1 and rs2 the next cycle -> both return 0x00510193 and wb_count=1.
REQ-029 x0: write 0x99999999 to x0 -> reads of x0 return 0 and wb_count is unchanged.
REQ-030 Bypass: in one cycle write 0x23232323 to x5 with rs1_addr=5 -> rs1_data=0x23232323 before the edge; write with wb_enable=0 -> old value is kept.
REQ-031 Sweep: write x1..x31 with value 0x10101010+i, then read all 31 -> each register matches and wb_count=31.
REQ-032 Mid-run reset: after REQ-031, pulse rst between clk edges -> every register reads 0 immediately and wb_count=0.
